uart_tx_fifo: RTL

Serial transmitter feeding the crossbar's `txd` pin. It is the transmit counterpart of the crossbar's UART receiver on `rxd`.
- The crossbar pushes bytes on a store to the UART data address.
- Bytes are buffered in a small FIFO and shifted out as 8N1 frames, LSB first.
- `full` back-pressures the crossbar's store path; the crossbar polls `busy`/`full` for the status register.

---
 rtl/uart_tx_fifo.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered serial transmitter driving the crossbar's txd pin.
//
// Bytes pushed by the crossbar are queued in a small circular FIFO. They are
// shifted out LSB first as 8N1 frames, or as 8E1 frames when
// UART_TX_PARITY_EN is defined.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD       line rate; DIV = CLK_FREQ/BAUD clocks per bit (DIV >= 2)
//   FIFO_DEPTH queued byte entries (power of 2, >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; aborts any frame in flight
//   wr_en      single-cycle push strobe
//   wr_data    byte to push
//   full       FIFO holds FIFO_DEPTH bytes; a push this cycle is dropped
//   busy       a frame is on the line or bytes are still queued
//   fifo_count bytes queued (the byte in the shifter is not counted)
//   txd        serial line output, idle high
//
// Optional feature macro: UART_TX_PARITY_EN. It adds an even-parity bit
// between the data bits and the stop bit.

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          txd
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;

  logic push;
  logic pop;
  logic bit_end;
  logic queued;

  assign queued  = (count_q != '0);
  assign push    = wr_en && (count_q != CW'(FIFO_DEPTH));
  assign bit_end = (baud_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (queued) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so back-to-back frames
          // carry no extra idle bit.
          if (queued) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    if (pop) begin
      shift_d  = mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The line driver is one register behind the state, so the start bit
  // appears one cycle after the pop.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = ^shift_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // busy spans the lagged line stage as well. It therefore stays high
  // until the last stop-bit cycle has actually left txd.
  always_comb begin
    busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign full       = (count_q == CW'(FIFO_DEPTH));

endmodule
